// File: rtl/sdram_read_arbiter.sv
// Two-port word read arbiter in front of the 16-bit Avalon bridge read channel, with ack-settle and watchdog abort.
// Optional starvation guard for port 1 is enabled by defining SDRAM_ARB_STARVE_GUARD_EN.
module sdram_read_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int MAX_CONSEC     = 4
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        req0_rden,
    input  logic [24:0] req0_addr,
    output logic        req0_ack,
    output logic [15:0] req0_rddata,
    input  logic        req1_rden,
    input  logic [24:0] req1_addr,
    output logic        req1_ack,
    output logic [15:0] req1_rddata,
    output logic [24:0] mem_addr,
    output logic        mem_rden,
    input  logic [15:0] mem_rddata,
    input  logic        mem_ack,
    output logic [1:0]  grant,
    output logic        timeout_err,
    output logic [7:0]  timeout_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [9:0] TIMEOUT_LIMIT = 10'(TIMEOUT_CYCLES);

    logic [1:0]  state_r;
    logic [24:0] mem_addr_r;
    logic        mem_rden_r;
    logic [1:0]  grant_r;
    logic [15:0] rddata0_r;
    logic [15:0] rddata1_r;
    logic        timeout_err_r;
    logic [7:0]  timeout_cnt_r;
    logic [9:0]  wdog_r;

    logic        any_req_s;
    logic        pick1_s;
    logic [9:0]  wdog_inc_s;
    logic        wdog_expired_s;

    assign any_req_s      = req0_rden | req1_rden;
    assign wdog_inc_s     = wdog_r + 10'd1;
    assign wdog_expired_s = (wdog_inc_s == TIMEOUT_LIMIT);

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] CONSEC_LIMIT = 8'(MAX_CONSEC);
    logic [7:0] consec_r;

    // Winner selection: port 0 first unless port 1 has been passed over MAX_CONSEC times in a row
    always_comb begin
        if (!req1_rden) begin
            pick1_s = 1'b0;
        end else if (!req0_rden) begin
            pick1_s = 1'b1;
        end else if (consec_r >= CONSEC_LIMIT) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
    end

    // Consecutive port 0 grants made while port 1 was waiting
    always_ff @(posedge clk50) begin
        if (reset) begin
            consec_r <= 8'd0;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            if (pick1_s || !req1_rden) begin
                consec_r <= 8'd0;
            end else begin
                consec_r <= consec_r + 8'd1;
            end
        end
    end
`else
    logic [7:0] unused_max_consec_s;
    assign unused_max_consec_s = 8'(MAX_CONSEC);

    // Winner selection: strict port 0 priority
    always_comb begin
        if (req0_rden) begin
            pick1_s = 1'b0;
        end else begin
            pick1_s = 1'b1;
        end
    end
`endif

    // Transaction sequencer: arbitrate, hold the bridge request, then wait for the ack to fall
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            mem_addr_r    <= 25'd0;
            mem_rden_r    <= 1'b0;
            grant_r       <= 2'b00;
            rddata0_r     <= 16'd0;
            rddata1_r     <= 16'd0;
            timeout_err_r <= 1'b0;
            timeout_cnt_r <= 8'd0;
            wdog_r        <= 10'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_r    <= ST_GRANT;
                        mem_rden_r <= 1'b1;
                        grant_r    <= pick1_s ? 2'b10 : 2'b01;
                        mem_addr_r <= pick1_s ? req1_addr : req0_addr;
                        wdog_r     <= 10'd0;
                    end
                end
                ST_GRANT: begin
                    if (mem_ack) begin
                        state_r    <= ST_RELEASE;
                        mem_rden_r <= 1'b0;
                        if (grant_r[0]) begin
                            rddata0_r <= mem_rddata;
                        end
                        if (grant_r[1]) begin
                            rddata1_r <= mem_rddata;
                        end
                    end else if (wdog_expired_s) begin
                        // Abort: the requester gets nothing and may retry from IDLE
                        state_r       <= ST_IDLE;
                        mem_rden_r    <= 1'b0;
                        grant_r       <= 2'b00;
                        timeout_err_r <= 1'b1;
                        if (timeout_cnt_r != 8'hFF) begin
                            timeout_cnt_r <= timeout_cnt_r + 8'd1;
                        end
                    end else begin
                        wdog_r <= wdog_inc_s;
                    end
                end
                ST_RELEASE: begin
                    if (!mem_ack) begin
                        state_r <= ST_IDLE;
                        grant_r <= 2'b00;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mem_rden_r <= 1'b0;
                    grant_r    <= 2'b00;
                end
            endcase
        end
    end

    assign req0_ack    = mem_ack & grant_r[0];
    assign req1_ack    = mem_ack & grant_r[1];
    assign req0_rddata = rddata0_r;
    assign req1_rddata = rddata1_r;
    assign mem_addr    = mem_addr_r;
    assign mem_rden    = mem_rden_r;
    assign grant       = grant_r;
    assign timeout_err = timeout_err_r;
    assign timeout_cnt = timeout_cnt_r;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Bench for sdram_read_arbiter: directed vector table, corner-case sequences and randomized transactions
// checked against a transaction-level reference model (bridge played by the bench).
module tb_sdram_read_arbiter;

    localparam int TO   = 8;
    localparam int MAXC = 4;

    logic        clk50 = 1'b0;
    logic        reset;
    logic        req0_rden, req1_rden;
    logic [24:0] req0_addr, req1_addr;
    logic        req0_ack, req1_ack;
    logic [15:0] req0_rddata, req1_rddata;
    logic [24:0] mem_addr;
    logic        mem_rden;
    logic [15:0] mem_rddata;
    logic        mem_ack;
    logic [1:0]  grant;
    logic        timeout_err;
    logic [7:0]  timeout_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_rd [2];
    int          m_to;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    int          m_consec;
`endif

    typedef struct {
        logic        r0;
        logic [24:0] a0;
        logic        r1;
        logic [24:0] a1;
        logic [15:0] data;
        int          delay;
        int          len;
        logic [1:0]  exp_grant;
        logic [24:0] exp_addr;
        logic [15:0] exp_rd0;
        logic [15:0] exp_rd1;
    } vec_t;

    vec_t vecs [6];

    sdram_read_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_CONSEC(MAXC)) dut (
        .clk50(clk50), .reset(reset),
        .req0_rden(req0_rden), .req0_addr(req0_addr), .req0_ack(req0_ack), .req0_rddata(req0_rddata),
        .req1_rden(req1_rden), .req1_addr(req1_addr), .req1_ack(req1_ack), .req1_rddata(req1_rddata),
        .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_rddata(mem_rddata), .mem_ack(mem_ack),
        .grant(grant), .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
    );

    always #5 clk50 = ~clk50;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_rd[0] = 16'h0000;
        m_rd[1] = 16'h0000;
        m_to = 0;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        m_consec = 0;
`endif
    endtask

    task automatic wait_rden(input string tag);
        int k;
        k = 0;
        while (!mem_rden && k < 4) begin
            tick();
            k++;
        end
        check({tag, "_rden_seen"}, 32'(mem_rden), 32'd1);
    endtask

    // Reference arbitration rule, applied once per arbitration decision
    task automatic model_arb(input logic r0, input logic r1, output int w);
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        if (!r1) begin
            w = 0; m_consec = 0;
        end else if (!r0) begin
            w = 1; m_consec = 0;
        end else if (m_consec >= MAXC) begin
            w = 1; m_consec = 0;
        end else begin
            w = 0; m_consec++;
        end
`else
        w = r0 ? 0 : 1;
`endif
    endtask

    // One transaction from IDLE back to IDLE; delay >= TO means the bridge never acks
    task automatic do_txn(input vec_t v, input string tag);
        req0_rden = v.r0; req0_addr = v.a0;
        req1_rden = v.r1; req1_addr = v.a1;
        tick();
        wait_rden(tag);
        check({tag, "_grant"}, 32'(grant), 32'(v.exp_grant));
        check({tag, "_addr"}, 32'(mem_addr), 32'(v.exp_addr));
        req0_rden = 1'b0;
        req1_rden = 1'b0;
        if (v.delay >= TO) begin
            repeat (TO - 1) tick();
            check({tag, "_rden_last"}, 32'(mem_rden), 32'd1);
            tick();
            check({tag, "_abort_rden"}, 32'(mem_rden), 32'd0);
            check({tag, "_abort_grant"}, 32'(grant), 32'd0);
        end else begin
            repeat (v.delay) tick();
            check({tag, "_rden_wait"}, 32'(mem_rden), 32'd1);
            mem_ack = 1'b1;
            mem_rddata = v.data;
            #1;
            check({tag, "_ack0"}, 32'(req0_ack), 32'(v.exp_grant[0]));
            check({tag, "_ack1"}, 32'(req1_ack), 32'(v.exp_grant[1]));
            tick();
            check({tag, "_rel_rden"}, 32'(mem_rden), 32'd0);
            check({tag, "_rel_grant"}, 32'(grant), 32'(v.exp_grant));
            mem_rddata = ~v.data;
            for (int i = 1; i < v.len; i++) begin
                tick();
                check({tag, "_sticky_rden"}, 32'(mem_rden), 32'd0);
                check({tag, "_sticky_grant"}, 32'(grant), 32'(v.exp_grant));
            end
            mem_ack = 1'b0;
            #1;
            check({tag, "_ackfall"}, 32'({req1_ack, req0_ack}), 32'd0);
            tick();
            check({tag, "_idle_grant"}, 32'(grant), 32'd0);
        end
        check({tag, "_rd0"}, 32'(req0_rddata), 32'(v.exp_rd0));
        check({tag, "_rd1"}, 32'(req1_rddata), 32'(v.exp_rd1));
    endtask

    initial begin
        int   w;
        int   cyc;
        vec_t v;
        logic [1:0] sel;

        vecs[0] = '{1'b1, 25'h000002C, 1'b0, 25'h0000000, 16'hBEEF, 3, 2, 2'b01, 25'h000002C, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 25'h0000000, 1'b1, 25'h1ABCDEF, 16'h1234, 0, 1, 2'b10, 25'h1ABCDEF, 16'hBEEF, 16'h1234};
        vecs[2] = '{1'b1, 25'h0000001, 1'b1, 25'h1FFFFFF, 16'h5A5A, 1, 6, 2'b01, 25'h0000001, 16'h5A5A, 16'h1234};
        vecs[3] = '{1'b0, 25'h0000000, 1'b1, 25'h0155555, 16'hFFFF, 7, 1, 2'b10, 25'h0155555, 16'h5A5A, 16'hFFFF};
        vecs[4] = '{1'b1, 25'h1000000, 1'b0, 25'h0000000, 16'h9999, TO, 1, 2'b01, 25'h1000000, 16'h5A5A, 16'hFFFF};
        vecs[5] = '{1'b1, 25'h0000000, 1'b0, 25'h0000000, 16'h0000, 0, 1, 2'b01, 25'h0000000, 16'h0000, 16'hFFFF};

        req0_rden = 1'b0; req0_addr = 25'd0;
        req1_rden = 1'b0; req1_addr = 25'd0;
        mem_ack = 1'b0; mem_rddata = 16'h0000;
        reset = 1'b1;
        tick();
        tick();
        check("rst_rden", 32'(mem_rden), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_acks", 32'({req1_ack, req0_ack}), 32'd0);
        check("rst_rd0", 32'(req0_rddata), 32'd0);
        check("rst_rd1", 32'(req1_rddata), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_tcnt", 32'(timeout_cnt), 32'd0);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end
        check("vec_terr", 32'(timeout_err), 32'd1);
        check("vec_tcnt", 32'(timeout_cnt), 32'd1);

        // Reset in the middle of GRANT, then a late ack that must be ignored
        req0_rden = 1'b1; req0_addr = 25'h0123456;
        tick();
        wait_rden("rstmid");
        req0_rden = 1'b0;
        reset = 1'b1;
        tick();
        check("rstmid_rden", 32'(mem_rden), 32'd0);
        check("rstmid_grant", 32'(grant), 32'd0);
        check("rstmid_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rddata = 16'hDEAD;
        #1;
        check("rstmid_ack0", 32'(req0_ack), 32'd0);
        tick();
        tick();
        check("rstmid_rd0", 32'(req0_rddata), 32'd0);
        check("rstmid_rd1", 32'(req1_rddata), 32'd0);
        check("rstmid_grant2", 32'(grant), 32'd0);
        mem_ack = 1'b0;
        tick();

        // Repeated timeouts with a held request: exact abort length, retry, counter saturation
        req0_rden = 1'b1; req0_addr = 25'h000ABCD;
        tick();
        for (int n = 1; n <= 258; n++) begin
            cyc = 0;
            while (mem_rden && cyc < 20) begin
                tick();
                cyc++;
            end
            check("to_len", 32'(cyc), 32'(TO));
            check("to_grant_off", 32'(grant), 32'd0);
            check("to_cnt", 32'(timeout_cnt), 32'((n > 255) ? 255 : n));
            check("to_err", 32'(timeout_err), 32'd1);
            tick();
            check("to_retry_grant", 32'(grant), 32'd1);
            check("to_retry_rden", 32'(mem_rden), 32'd1);
        end
        req0_rden = 1'b0;
        mem_ack = 1'b1;
        mem_rddata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        tick();
        check("to_final_rd0", 32'(req0_rddata), 32'h7777);

        // Continuous contention on both ports
        do_reset();
        req0_rden = 1'b1; req0_addr = 25'h0AAAAAA;
        req1_rden = 1'b1; req1_addr = 25'h1555555;
        for (int i = 0; i < 10; i++) begin
            tick();
            wait_rden("cont");
            model_arb(1'b1, 1'b1, w);
            check($sformatf("cont%0d_grant", i), 32'(grant), (w == 1) ? 32'd2 : 32'd1);
            check($sformatf("cont%0d_addr", i), 32'(mem_addr), (w == 1) ? 32'h1555555 : 32'h0AAAAAA);
            mem_ack = 1'b1;
            mem_rddata = 16'hC000 + 16'(i);
            #1;
            check($sformatf("cont%0d_ack1", i), 32'(req1_ack), (w == 1) ? 32'd1 : 32'd0);
            m_rd[w] = mem_rddata;
            tick();
            mem_ack = 1'b0;
            check($sformatf("cont%0d_rd0", i), 32'(req0_rddata), 32'(m_rd[0]));
            check($sformatf("cont%0d_rd1", i), 32'(req1_rddata), 32'(m_rd[1]));
            tick();
        end
        req0_rden = 1'b0;
        req1_rden = 1'b0;
        tick();

        // Randomized transactions against the reference model
        do_reset();
        for (int i = 0; i < 150; i++) begin
            sel = 2'($urandom_range(1, 3));
            v.r0 = sel[0];
            v.r1 = sel[1];
            v.a0 = 25'($urandom);
            v.a1 = 25'($urandom);
            v.data = 16'($urandom);
            v.delay = $urandom_range(0, TO + 1);
            v.len = $urandom_range(1, 4);
            model_arb(v.r0, v.r1, w);
            v.exp_grant = (w == 1) ? 2'b10 : 2'b01;
            v.exp_addr = (w == 1) ? v.a1 : v.a0;
            if (v.delay < TO) begin
                m_rd[w] = v.data;
            end else begin
                m_to++;
            end
            v.exp_rd0 = m_rd[0];
            v.exp_rd1 = m_rd[1];
            do_txn(v, $sformatf("rnd%0d", i));
        end
        check("rnd_tcnt", 32'(timeout_cnt), 32'((m_to > 255) ? 255 : m_to));
        check("rnd_terr", 32'(timeout_err), (m_to > 0) ? 32'd1 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdram_read_arbiter.md
# sdram_read_arbiter

Two-port read arbiter sharing the single 16-bit Avalon bridge read channel (25-bit word address, rden/acknowledge handshake) between the audio PCM streamer (port 0) and a second reader such as the video fetcher (port 1). It sits between the requesters and the bridge and serialises one word read at a time. It also performs the bridge's acknowledge-settle sequencing, aborts reads that never complete, and keeps error visibility.

## Interface
- TIMEOUT_CYCLES, 1023: GRANT cycles without acknowledge before abort; 1..1023.
- MAX_CONSEC, 4: starvation-guard limit for consecutive port 0 grants; used only with the macro.
- clk50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req0_rden  in  1  port 0 read request (level).
- req0_addr  in  25  port 0 word address.
- req0_ack  out  1  acknowledge to port 0.
- req0_rddata  out  16  read data to port 0.
- req1_rden, req1_addr, req1_ack, req1_rddata: same as port 0, for port 1.
- mem_addr  out  25  bridge address.
- mem_rden  out  1  bridge read enable.
- mem_rddata  in  16  bridge read data.
- mem_ack  in  1  bridge acknowledge (level; may stay high several cycles).
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  sticky; set by any abort.
- timeout_cnt  out  8  saturating abort count.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - mem_rden=0; grant=00.
  - If any reqN_rden is high, pick the winner, latch its address into mem_addr, go to GRANT.
  - Default policy is strict priority: port 0 wins when both request.
- GRANT:
  - mem_rden=1; grant is one-hot on the winner.
  - When mem_ack=1: capture mem_rddata into the winner's rddata register and go to RELEASE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES: go to IDLE, set timeout_err, increment timeout_cnt (saturates at 255). No ack or data reaches the requester; a still-asserted rden is re-arbitrated as a retry.
- RELEASE:
  - mem_rden=0; grant is held.
  - Wait for mem_ack=0, then go to IDLE.
- reqN_ack = mem_ack AND grant[N], in both GRANT and RELEASE. Requesters therefore see the bridge's level acknowledge and its fall.
- reqN_rddata holds the last word captured for port N until that port's next capture. The value does not change on the other port's transfers.
- mem_addr is stable for the whole transaction. The requester may change reqN_addr after it sees ack.
- Watchdog clears on every entry to GRANT.

## Timing
- Reset values:
  - State IDLE; mem_rden=0; mem_addr=0; grant=00.
  - req0_ack=req1_ack=0; req0_rddata=req1_rddata=0.
  - timeout_err=0; timeout_cnt=0.
- A reset asserted mid-transaction forces IDLE and mem_rden=0 on that edge; no data is captured.
- Latency: rden sampled high at edge t puts mem_rden high from t+1, with grant updated at the same edge.
- Data: mem_ack sampled at edge a gives reqN_rddata valid from a+1; reqN_ack is high combinationally during cycle a.
- Minimum transaction: GRANT(1) + RELEASE(1) + IDLE(1) = 3 cycles per word. The best case occurs when ack arrives in the first GRANT cycle and falls one cycle later.
- Simultaneous requests in IDLE resolve per policy; the loser keeps rden high and is served on the next IDLE.
- A request dropped during GRANT does not cancel the read; the transaction completes.
- mem_ack already high on entry to GRANT counts as the acknowledge. Avoiding this is the purpose of RELEASE.
- Timeout: abort occurs on the edge where the watchdog equals TIMEOUT_CYCLES, which is TIMEOUT_CYCLES GRANT cycles after entry.

## Configuration
- Macro: SDRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive port 0 grants made while req1_rden is high.
  - When it reaches MAX_CONSEC, port 1 wins the next contended arbitration and the counter clears.
  - The counter also clears on any port 1 grant and whenever req1_rden is low at arbitration.
- Undefined: strict port 0 priority; the counter logic is absent. Port 1 may starve indefinitely.

## Test plan
- Single read, port 0 only:
  - Stimulus: addr 0x000002C; mem_ack high for 2 cycles starting 3 cycles after mem_rden; mem_rddata 0xBEEF.
  - Required: mem_addr=0x000002C; req0_rddata=0xBEEF; req0_ack mirrors mem_ack; grant 01 → 00 after ack falls.
- Contention, strict priority (macro undefined):
  - Stimulus: both ports request continuously; bridge acks each read.
  - Required: 10 consecutive grants to port 0; req1_ack never high.
- Starvation guard (macro defined, MAX_CONSEC=4):
  - Stimulus: both ports request continuously.
  - Required: grant sequence 0,0,0,0,1,0,0,0,0,1; req1_rddata updates only on port 1 transfers.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; mem_ack held low.
  - Required: mem_rden high for exactly 8 cycles then low; timeout_err=1; timeout_cnt=1; grant re-asserts on the next cycle while rden stays high.
- Reset mid-GRANT:
  - Stimulus: assert reset in GRANT, then send mem_ack.
  - Required: mem_rden=0 and grant=00 after the edge; rddata remains 0; ack is ignored.
- Sticky ack from bridge:
  - Stimulus: mem_ack held high 6 cycles.
  - Required: exactly one capture; state stays RELEASE until ack falls; no second GRANT during that period.
